// File: rtl/alu_seq_pipe.sv
// Sequential ALU with valid/ready handshakes on both sides, registered result and flags,
// and an iterative shift-add multiplier that also serves multiply-accumulate.
module alu_seq_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_select,
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_A,
  output logic             o_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zero,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_MAC = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sum;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  assign o_in_ready = (state == IDLE) || (state == OUT && i_out_ready);
  assign accept     = i_valid && o_in_ready;
  assign is_mul     = (i_select == OP_MUL) || (i_select == OP_MAC);
  assign o_busy     = (state == MUL);
  assign mul_done   = (state == MUL) && (cnt == LAST);
  assign acc_sum    = mplier[0] ? acc + mcand : acc;

  // Single-cycle results; carry is the 33rd bit for ADD and the borrow for SUB.
  always_comb begin
    add_ext   = {1'b0, i_in0} + {1'b0, i_in1};
    sub_ext   = {1'b0, i_in0} - {1'b0, i_in1};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (i_select)
      OP_ADD: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
        alu_ovf   = (i_in0[WIDTH-1] == i_in1[WIDTH-1]) &&
                    (add_ext[WIDTH-1] != i_in0[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
        alu_ovf   = (i_in0[WIDTH-1] != i_in1[WIDTH-1]) &&
                    (sub_ext[WIDTH-1] != i_in0[WIDTH-1]);
      end
      OP_AND: alu_res = i_in0 & i_in1;
      OP_OR:  alu_res = i_in0 | i_in1;
      OP_XOR: alu_res = i_in0 ^ i_in1;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_in0) < $signed(i_in1))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = is_mul ? MUL : OUT;
      MUL:  if (cnt == LAST) next_state = OUT;
      OUT:  if (i_out_ready) next_state = accept ? (is_mul ? MUL : OUT) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_out      <= '0;
      o_valid    <= 1'b0;
      o_zero     <= 1'b0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand   <= i_in0;
        mplier  <= i_in1;
        acc     <= (i_select == OP_MAC) ? i_A : '0;
        cnt     <= '0;
        o_valid <= 1'b0;
      end else begin
        o_out      <= alu_res;
        o_zero     <= (alu_res == '0);
        o_carry    <= alu_carry;
        o_overflow <= alu_ovf;
        o_valid    <= 1'b1;
      end
    end else if (state == MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_done) begin
        o_out      <= acc_sum;
        o_zero     <= (acc_sum == '0);
        o_carry    <= 1'b0;
        o_overflow <= 1'b0;
        o_valid    <= 1'b1;
      end
    end else if (state == OUT && i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_seq_pipe.md
# alu_seq_pipe

Parametrised sequential ALU that succeeds the fixed 32-bit ALU. It adds a valid/ready handshake on both sides, a registered result with status flags, and an iterative shift-add multiplier with a multiply-accumulate mode. It sits between an operand-issuing controller and a result consumer. Only one operation is in flight at a time.

## Interface
- WIDTH, 32, datapath width in bits (minimum 2)
- i_clk  input  1  clock, rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_valid  input  1  operands and opcode presented
- o_in_ready  output  1  block accepts an operation this cycle
- i_select  input  3  opcode
- i_in0  input  WIDTH  operand 0
- i_in1  input  WIDTH  operand 1
- i_A  input  WIDTH  accumulator addend, used only by MAC
- o_valid  output  1  result and flags valid
- i_out_ready  input  1  consumer takes the result this cycle
- o_out  output  WIDTH  result
- o_zero  output  1  o_out == 0
- o_carry  output  1  carry-out for ADD, borrow (in0 < in1 unsigned) for SUB, 0 otherwise
- o_overflow  output  1  signed overflow for ADD/SUB, 0 otherwise
- o_busy  output  1  multiplier iterating

## Operation
- Opcodes:
  - 000 ADD: in0+in1
  - 001 SUB: in0−in1
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MUL: low WIDTH bits of in0*in1, unsigned
  - 110 MAC: low WIDTH bits of A + in0*in1
  - 111 SLT: 1 if in0 < in1 signed, else 0
- Accept: i_valid && o_in_ready at a rising edge. Operands, i_A and opcode are sampled only at accept. i_valid while o_in_ready=0 is ignored; the producer holds its inputs.
- o_in_ready = (state==IDLE) || (state==OUT && i_out_ready). This is combinational from state and i_out_ready.
- FSM states: IDLE, MUL, OUT.
  - IDLE, accept single-cycle op: compute result, register result and flags, go to OUT.
  - IDLE, accept MUL/MAC: load mcand=in0, mplier=in1, acc=(MAC ? A : 0), cnt=0, go to MUL.
  - MUL, each cycle: if mplier[0], acc += mcand (mod 2^WIDTH); mcand <<= 1; mplier >>= 1; cnt++. When cnt==WIDTH−1 in this cycle, register acc as the result and go to OUT. MUL therefore lasts exactly WIDTH cycles.
  - OUT with i_out_ready=0: hold all outputs stable.
  - OUT with i_out_ready=1 and no new accept: go to IDLE.
  - OUT with i_out_ready=1 and a simultaneous accept: take the new op as from IDLE (back-to-back).
- Flags are registered together with o_out. For MUL, MAC, logic ops and SLT: o_carry=0 and o_overflow=0. o_zero always reflects the registered o_out.
- o_busy=1 exactly while in MUL.
- All arithmetic is modulo 2^WIDTH. Overflow = operand signs match (ADD) or differ (SUB), and the result sign differs from in0.

## Timing
- Reset (i_reset=0, async): state=IDLE; o_out=0, o_valid=0, o_zero=0, o_carry=0, o_overflow=0, o_busy=0. o_in_ready reads 1 but no accept occurs while reset is asserted.
- Reset asserted mid-MUL or in OUT aborts the operation immediately. No result is delivered.
- Single-cycle op accepted at edge k: o_valid=1 from edge k+1.
- MUL/MAC accepted at edge k: o_busy=1 from k+1 to k+WIDTH. o_valid=1 from edge k+WIDTH+1.
- o_valid deasserts at the edge where i_out_ready=1 is seen, unless a back-to-back single-cycle op is accepted at that same edge. In that case o_valid stays 1 with the new result.
- Throughput: one single-cycle op per cycle under continuous i_out_ready=1. MUL/MAC give one result per WIDTH+1 cycles.

## Test plan
- WIDTH=32, ADD in0=0xD4, in1=0xD5: o_out=0x1A9, carry=0, overflow=0, zero=0; o_valid exactly 1 cycle after accept.
- SUB in0=0xD4, in1=0xD5: o_out=0xFFFFFFFF, carry=1, overflow=0. Then ADD 0x7FFFFFFF+0x1: o_out=0x80000000, overflow=1. Then XOR 0xD4^0xD4: o_out=0, zero=1.
- MUL 0xD4×0xD5: o_out=0xB064 with o_valid 33 cycles after accept and o_busy high for 32 cycles. MAC with A=0xD6: o_out=0xB13A. MUL 0xFFFFFFFF×0xFFFFFFFF: o_out=0x1.
- Backpressure: hold i_out_ready=0 for 5 cycles after the result appears. o_out and flags stay stable, and o_in_ready=0. Then raise i_out_ready with i_valid=1 (OR 0xF0|0x0F): the next cycle shows o_out=0xFF with o_valid continuous.
- Streaming: 4 ADDs back-to-back with i_out_ready=1 produce 4 results on 4 consecutive cycles.
- Assert i_reset=0 for one cycle 10 cycles into a MUL: all outputs go to 0 immediately and state returns to IDLE. No stale result appears afterwards, and a following ADD 1+1 returns 0x2.
